// File: rtl/alu_bitserial_logic.sv
// alu_bitserial_logic: bit-serial bitwise logic unit.
// A command carries an opcode and two operands over a valid/ready port.
// The block then runs them through a single 1-bit logic cell, LSB first,
// one bit per clock. The WIDTH-bit result is returned over a valid/ready
// result port.
// Optional build macro ALU_SEQ_OPCOUNT_EN adds the ops_done port. ops_done
// is a saturating 16-bit count of completed result handshakes.
module alu_bitserial_logic #(
  parameter int WIDTH = 8,   // operand/result width, >= 2
  parameter int CNT_W = 4    // bit counter width, 2**CNT_W >= WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_inp1,
  input  logic [WIDTH-1:0] cmd_inp2,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_out,
  output logic             res_zero,
  output logic             busy
`ifdef ALU_SEQ_OPCOUNT_EN
  ,
  output logic [15:0]      ops_done
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           state, state_next;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] a_sh, b_sh, r_sh;
  logic [CNT_W-1:0] cnt;
  logic             idle_q;
  logic             bit_val;
  logic             accept;
  logic             res_hs;

  assign accept = cmd_valid && cmd_ready;
  assign res_hs = (state == DONE) && res_ready;

  // Next-state logic for the IDLE -> SHIFT -> DONE sequence.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    state_next = state;
    case (state)
      IDLE:    if (accept)          state_next = SHIFT;
      SHIFT:   if (cnt == LAST_BIT) state_next = DONE;
      DONE:    if (res_ready)       state_next = IDLE;
      default:                      state_next = IDLE;
    endcase
  end

  // The single 1-bit logic cell, fed by the operand LSBs.
  always_comb begin
    bit_val = 1'b0;
    case (op_q)
      3'b000:  bit_val =   a_sh[0] & b_sh[0];
      3'b001:  bit_val =   a_sh[0] | b_sh[0];
      3'b010:  bit_val =   a_sh[0] ^ b_sh[0];
      3'b011:  bit_val = ~(a_sh[0] & b_sh[0]);
      3'b100:  bit_val = ~(a_sh[0] | b_sh[0]);
      3'b101:  bit_val = ~(a_sh[0] ^ b_sh[0]);
      3'b110:  bit_val =  ~a_sh[0];
      default: bit_val =   b_sh[0];
    endcase
  end

  // State register plus the registered idle flag that drives cmd_ready.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    if (rst) begin
      state  <= IDLE;
      idle_q <= 1'b0;
    end else begin
      state  <= state_next;
      idle_q <= (state_next == IDLE);
    end
  end

  // Operand/result shift registers and the bit counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q <= '0;
      a_sh <= '0;
      b_sh <= '0;
      r_sh <= '0;
      cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_q <= cmd_op;
            a_sh <= cmd_inp1;
            b_sh <= cmd_inp2;
            r_sh <= '0;
            cnt  <= '0;
          end
        end
        SHIFT: begin
          r_sh <= {bit_val, r_sh[WIDTH-1:1]};
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          cnt  <= cnt + 1'b1;
        end
        DONE: begin
          // Result is consumed; drop it so nothing stale lingers.
          if (res_hs) r_sh <= '0;
        end
        default: ;
      endcase
    end
  end

`ifdef ALU_SEQ_OPCOUNT_EN
  logic [15:0] ops_cnt;

  // Saturating count of completed result handshakes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                             ops_cnt <= '0;
    else if (res_hs && ops_cnt != 16'hFFFF) ops_cnt <= ops_cnt + 16'd1;
  end

  assign ops_done = ops_cnt;
`endif

  assign cmd_ready = idle_q;
  assign busy      = (state != IDLE);
  assign res_valid = (state == DONE);
  assign res_out   = res_valid ? r_sh : '0;
  assign res_zero  = res_valid && (r_sh == '0);

endmodule
